// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Quotient goes to lo, remainder to hi; one quotient bit per cycle.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, FIN, DZ} state_t;
    state_t           state;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic [CW-1:0]    cnt;
    logic             sign_q, sign_r;
    logic             a_neg, b_neg, ge;
    logic [WIDTH-1:0] a_mag, b_mag, diff;
    logic [WIDTH:0]   shl;
    always_comb begin
        a_neg = is_signed & a[WIDTH-1];
        b_neg = is_signed & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
        // trial value is WIDTH+1 bits so the borrow of the subtract is never lost
        shl   = {rem, quo[WIDTH-1]};
        ge    = shl >= {1'b0, dvs};
        diff  = shl[WIDTH-1:0] - dvs;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            lo          <= '0;
            hi          <= '0;
            div_by_zero <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
        end else if (cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    // on divide-by-zero quo carries the raw dividend through to hi
                    state  <= (b == '0) ? DZ : CALC;
                    busy   <= 1'b1;
                    quo    <= (b == '0) ? a : a_mag;
                    dvs    <= b_mag;
                    sign_q <= a_neg ^ b_neg;
                    sign_r <= a_neg;
                    rem    <= '0;
                    cnt    <= CW'(WIDTH);
                end
                CALC: begin
                    rem   <= ge ? diff : shl[WIDTH-1:0];
                    quo   <= {quo[WIDTH-2:0], ge};
                    cnt   <= cnt - CW'(1);
                    state <= (cnt == CW'(1)) ? FIN : CALC;
                end
                FIN: begin
                    lo          <= sign_q ? -quo : quo;
                    hi          <= sign_r ? -rem : rem;
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                DZ: begin
                    lo          <= '1;
                    hi          <= quo;
                    div_by_zero <= 1'b1;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors for div_unit, checked every cycle against a
// cycle-count/arithmetic reference model plus hand-computed literals.
module tb_div_unit;
    localparam int W = 32;
    logic         clk = 1'b0, rst = 1'b1, start = 1'b0, is_signed = 1'b0, cancel = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] lo, hi;
    int           n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .done(done), .lo(lo), .hi(hi), .div_by_zero(div_by_zero)
    );

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void ref_div(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                                    output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint xa, ya, qq, rr;
        if (y == '0) begin
            q = '1;
            r = x;
            z = 1'b1;
        end else begin
            xa = s ? longint'($signed(x)) : longint'({32'b0, x});
            ya = s ? longint'($signed(y)) : longint'({32'b0, y});
            qq = xa / ya;
            rr = xa % ya;
            q  = qq[W-1:0];
            r  = rr[W-1:0];
            z  = 1'b0;
        end
    endfunction

    // reference model: outputs expected after each rising edge
    logic         m_busy = 0, m_done = 0, m_dz = 0, p_dz = 0;
    logic [W-1:0] m_lo = '0, m_hi = '0, p_lo = '0, p_hi = '0;
    bit           inflight = 0;
    int           left = 0;
    always @(posedge clk) begin
        if (rst) begin
            inflight = 0; m_busy = 0; m_done = 0; m_lo = '0; m_hi = '0; m_dz = 0;
        end else begin
            m_done = 0;
            if (inflight && cancel) begin
                inflight = 0;
                m_busy   = 0;
            end else if (inflight) begin
                left--;
                if (left == 0) begin
                    inflight = 0; m_busy = 0; m_done = 1;
                    m_lo = p_lo; m_hi = p_hi; m_dz = p_dz;
                end
            end else if (start && !cancel) begin
                inflight = 1;
                m_busy   = 1;
                left     = (b == '0) ? 1 : W + 1;
                ref_div(is_signed, a, b, p_lo, p_hi, p_dz);
            end
        end
    end

    always @(negedge clk) begin
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("lo", lo, m_lo);
        check("hi", hi, m_hi);
        check("div_by_zero", div_by_zero, m_dz);
    end

    task automatic go(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1; is_signed = s; a = x; b = y;
        @(posedge clk); #1;
        start = 0; a = $urandom; b = $urandom;
        check("busy T1", busy, 1'b1);
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: no done within 200 cycles");
        end
    endtask

    task automatic run(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] elo, input logic [W-1:0] ehi, input logic edz, input int lat);
        int n;
        go(s, x, y);
        wait_done(1, n);
        check("latency", n, lat);
        check("lo literal", lo, elo);
        check("hi literal", hi, ehi);
        check("dz literal", div_by_zero, edz);
        check("model lo literal", m_lo, elo);
        check("model hi literal", m_hi, ehi);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        check("reset busy", busy, 1'b0);
        check("reset lo", lo, '0);
        check("reset hi", hi, '0);
        run(0, 100, 7, 14, 2, 0, 34);
        run(1, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 34);
        run(1, 7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1, 0, 34);
        run(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 34);
        run(0, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 0, 34);
        run(1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 14, 32'hFFFF_FFFE, 0, 34);
        run(0, 32'h1234, 0, 32'hFFFF_FFFF, 32'h1234, 1, 2);
        run(0, 100, 7, 14, 2, 0, 34);
        // start while busy is ignored
        go(0, 100, 7);
        repeat (4) begin @(posedge clk); #1; end
        start = 1; a = 50; b = 5;
        @(posedge clk); #1;
        start = 0;
        wait_done(6, n);
        check("ignore latency", n, 34);
        check("ignore lo", lo, 14);
        check("ignore hi", hi, 2);
        // cancel mid-operation
        go(0, 9, 4);
        repeat (9) begin @(posedge clk); #1; end
        cancel = 1;
        @(posedge clk); #1;
        cancel = 0;
        check("cancel busy", busy, 1'b0);
        repeat (40) begin
            check("cancel no done", done, 1'b0);
            @(posedge clk); #1;
        end
        check("cancel lo", lo, 14);
        check("cancel hi", hi, 2);
        // cancel beats start in IDLE
        cancel = 1; start = 1; a = 5; b = 1;
        @(posedge clk); #1;
        cancel = 0; start = 0;
        check("cancel+start busy", busy, 1'b0);
        run(0, 9, 4, 2, 1, 0, 34);
        // reset mid-operation
        go(0, 100, 3);
        repeat (19) begin @(posedge clk); #1; end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst lo", lo, '0);
        check("rst hi", hi, '0);
        check("rst dz", div_by_zero, 1'b0);
        run(0, 100, 3, 33, 1, 0, 34);
        go(0, 32'hDEAD_BEEF, 32'h1234);
        wait_done(1, n);
        check("model-only latency", n, 34);
        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle radix-2 restoring divider for the execute stage, serving DIV and DIVU. The decoder flags these as mult/div operations with HI/LO enables both set. This unit accepts the two register operands plus a signedness bit and produces the quotient for LO and the remainder for HI. The pipeline stalls on `busy`, and HI/LO are written on `done`.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width. The iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  the single clock; every register updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  request a division; accepted only in IDLE.
- `is_signed`  in  1  1 = DIV (two's complement), 0 = DIVU. Sampled with `start`.
- `a`  in  WIDTH  dividend (rs). Sampled with `start`.
- `b`  in  WIDTH  divisor (rt). Sampled with `start`.
- `cancel`  in  1  flush from an exception or branch kill. Aborts any operation in progress.
- `busy`  out  1  operation in flight; the pipeline holds the execute stage while high.
- `done`  out  1  one-cycle pulse; `hi` and `lo` are valid from this cycle on.
- `lo`  out  WIDTH  quotient. Holds its value until the next `done`.
- `hi`  out  WIDTH  remainder. Holds its value until the next `done`.
- `div_by_zero`  out  1  set with `done` when `b` was 0. Held with the result.

## Operation
- States: IDLE, CALC, FIN, DZ.
- IDLE:
  - `start` with `b`≠0 → CALC. Latch the magnitudes |a| and |b| (abs only when `is_signed`). Latch sign_q = a[MSB]^b[MSB] and sign_r = a[MSB] (both 0 when unsigned). Clear the remainder accumulator. Load counter = WIDTH.
  - `start` with `b`=0 → DZ.
- CALC: one quotient bit per cycle.
  - Shift {rem, quo} left by 1.
  - Trial subtract: rem − divisor. If non-negative, keep the difference and set quo[0]=1.
  - Decrement the counter. When it reaches 0 (after WIDTH iterations) → FIN.
- FIN:
  - Drive `lo` = sign_q ? −quo : quo and `hi` = sign_r ? −rem : rem.
  - Clear `div_by_zero`, pulse `done`, → IDLE.
- DZ: drive `lo` = all ones and `hi` = a as sampled. Set `div_by_zero`, pulse `done`, → IDLE.
- Width rules:
  - The magnitude of the most negative value is carried as an unsigned WIDTH-bit number 2^(WIDTH−1).
  - Remainder accumulator is WIDTH+1 bits, so the trial subtract never loses the borrow.
  - Negation is two's complement modulo 2^WIDTH. As a result, 0x80000000 / −1 (signed) gives `lo`=0x80000000 and `hi`=0 with no trap.
- `start` outside IDLE is ignored: no queuing and no restart.
- `cancel`:
  - In any state, `cancel` forces IDLE on the next edge.
  - No `done` pulse is produced for the cancelled operation.
  - `hi`, `lo` and `div_by_zero` keep their previous values.
  - `cancel` together with `start` in IDLE: `cancel` wins and nothing starts.
- `rst`: state IDLE; `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_by_zero`=0; internal counter and accumulators cleared. Reset has priority over `cancel` and `start`.

## Timing
- T0 is the cycle `start` is accepted in IDLE.
- Normal division:
  - `busy`=1 at T1 through T(WIDTH+1).
  - `done`=1 only at T(WIDTH+2), i.e. T34 for WIDTH=32, with `busy`=0 in that cycle.
  - `hi` and `lo` change exactly at T34.
- Divide by zero: `busy`=1 at T1 only; `done`=1 at T2.
- Back-to-back: a new `start` is accepted in the `done` cycle (the unit is back in IDLE). Its `busy` begins the cycle after.
- `busy` and `done` are never high in the same cycle.
- `busy` is a registered output; there is no combinational path from `start` to `busy`.
- Cancel timing: `cancel` at cycle Tk (1≤k≤WIDTH+1) → `busy`=0 at Tk+1, and no `done` for that operation.
- Operands may change after T0 without affecting the result.

## Test plan
- Unsigned: `start`, `is_signed`=0, `a`=100, `b`=7 → at T34 `done`=1, `lo`=14, `hi`=2, `div_by_zero`=0; `busy` high T1–T33.
- Signed signs: `a`=−7 (0xFFFFFFF9), `b`=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Then `a`=7, `b`=−2 → `lo`=0xFFFFFFFD, `hi`=1.
- Overflow corner: signed 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0. Unsigned 0xFFFFFFFF / 1 → `lo`=0xFFFFFFFF, `hi`=0.
- Divide by zero: `a`=0x1234, `b`=0 → `done` at T2, `lo`=0xFFFFFFFF, `hi`=0x1234, `div_by_zero`=1. A following normal divide clears `div_by_zero`.
- Cancel and ignore:
  - Start 100/7, then pulse `start` with 50/5 at T5 → the T5 request is ignored and the result is still 14/2 at T34.
  - Start again, assert `cancel` at T10 → `busy`=0 at T11, no `done`, `hi`/`lo` still 2/14.
  - Next `start` 9/4 → `lo`=2, `hi`=1.
- Reset mid-operation: assert `rst` at T20 → next cycle all outputs 0 and state IDLE, with no `done` pulse afterwards. A `start` the cycle after `rst` deasserts completes normally.
